ifetch_icache: RTL and testbench
================================

// Module: ifetch_icache
// PURPOSE
//  Parametrised instruction-fetch unit with a set-associative instruction cache.
//  Sits between the memory controller (block refills) and the instruction decoder.
//  Adds over the previous fetch unit: configurable geometry, 1/2-way LRU, inst_pc output,
//  whole-cache invalidate (fence.i), safe redirect while a refill is outstanding.
// PARAMETERS
//  BLK_WORDS  16     32-bit instructions per cache block (power of 2, >=2)
//  SETS       16     number of sets (power of 2, >=2)
//  WAYS       2      associativity, 1 or 2
//  RESET_PC   32'h0  pc after reset
//  derived: OFF_W=log2(BLK_WORDS)+2, IDX_W=log2(SETS), TAG_W=32-OFF_W-IDX_W
// PORTS
//  clk            in   1             clock, all state on posedge
//  rst            in   1             asynchronous reset, active-high
//  rdy            in   1             global enable; 0 freezes every register
//  rs_nxt_full    in   1             RS full next cycle -> stall issue
//  lsb_nxt_full   in   1             LSB full next cycle -> stall issue
//  rob_nxt_full   in   1             ROB full next cycle -> stall issue
//  inst_rdy       out  1             inst/inst_pc valid this cycle (one-cycle pulse per inst)
//  inst           out  32            fetched instruction
//  inst_pc        out  32            address of inst
//  mc_en          out  1             refill request, held high until mc_done
//  mc_pc          out  32            block-aligned refill address (low OFF_W bits 0)
//  mc_done        in   1             refill data valid, one-cycle pulse
//  mc_data        in   32*BLK_WORDS  refill block, word i at bits [32i+31:32i]
//  rob_set_pc_en  in   1             redirect strobe
//  rob_set_pc     in   32            redirect target
//  icache_flush   in   1             invalidate all lines
// BEHAVIOUR
//  Reset (async): pc=RESET_PC; inst_rdy=0, inst=0, inst_pc=0, mc_en=0, mc_pc=0;
//   all valid bits and LRU bits=0; state=IDLE. Reset mid-refill aborts it; a later mc_done is ignored.
//  rdy=0: no register changes; inputs ignored that cycle.
//  Address split: pc[OFF_W-1:2]=word, pc[OFF_W+IDX_W-1:OFF_W]=index, pc[31:OFF_W+IDX_W]=tag.
//  hit (combinational): any way w of set[index] with valid && tag match; hit way selects the word.
//  Issue priority per cycle:
//   1 rob_set_pc_en: pc<=rob_set_pc, inst_rdy<=0.
//   2 else hit && no *_nxt_full: inst<=word, inst_pc<=pc, inst_rdy<=1, pc<=pc+4 (32-bit wrap);
//     LRU[index]<=other way (WAYS=2).
//   3 else inst_rdy<=0, pc holds.
//  Refill FSM (independent of issue, same cycle):
//   IDLE: if !hit && !rob_set_pc_en && !icache_flush -> mc_en<=1, mc_pc<={pc[31:OFF_W],0},
//     drop<=0, WAIT_MEM.
//   WAIT_MEM: mc_en and mc_pc held. On mc_done: mc_en<=0, IDLE; if !drop write line into
//     victim way of set[mc_pc index]: first invalid way (way0 first), else LRU way;
//     set valid, tag; LRU<=other way.
//   Redirect during WAIT_MEM does not cancel: fill is still written (address data is correct),
//    then the new pc misses/hits normally. New request no earlier than the cycle after mc_done.
//  icache_flush: all valid<=0 next edge; in WAIT_MEM sets drop=1 so the in-flight fill is
//   discarded; flush coinciding with mc_done discards that fill. Flush takes priority
//   over issue: no inst issued in the flush cycle.
//  Hit on a line filled at edge N: usable from cycle N+1 (no fill bypass).
//  WAYS=1: LRU unused, victim always way0.
// TESTING
//  1 Reset, mc returns block of word i = 32'h1000+i at mc_done -> mc_pc=0, then inst_rdy with
//    inst 1000,1001,... inst_pc 0,4,8 one per cycle.
//  2 Stall: rob_nxt_full=1 for 3 cycles mid-stream -> inst_rdy=0, pc frozen, resumes exactly
//    at next word, no skip or duplicate.
//  3 WAYS=2, SETS=16, BLK_WORDS=16: fill 0x000, 0x400, then 0x800 (same set 0) -> 0x800 evicts
//    LRU line; re-fetch of the line just used before the 0x800 fill still hits, no mc_en.
//  4 Redirect to 0x2000 while refill of 0x40 pending -> 0x40 line still written; next mc_pc=0x2000;
//    first inst_pc after redirect =0x2000.
//  5 icache_flush while WAIT_MEM, mc_done one cycle later -> line not written; re-fetch of
//    same pc raises mc_en again.
//  6 rdy=0 across mc_done pulse -> pulse ignored, mc_en stays 1; async rst mid-refill ->
//    outputs zero immediately.

Source files
------------

// File: rtl/ifetch_icache_if.sv
// Fetch-unit bus bundle: decoder-side instruction output, memory-controller refill
// handshake, and the ROB redirect / fence.i controls.
interface ifetch_icache_if #(
  parameter int BLK_WORDS = 16
);
  logic                   inst_rdy;
  logic [31:0]            inst;
  logic [31:0]            inst_pc;
  logic                   mc_en;
  logic [31:0]            mc_pc;
  logic                   mc_done;
  logic [32*BLK_WORDS-1:0] mc_data;
  logic                   rob_set_pc_en;
  logic [31:0]            rob_set_pc;
  logic                   icache_flush;

  modport master (
    output inst_rdy, inst, inst_pc, mc_en, mc_pc,
    input  mc_done, mc_data, rob_set_pc_en, rob_set_pc, icache_flush
  );

  modport slave (
    input  inst_rdy, inst, inst_pc, mc_en, mc_pc,
    output mc_done, mc_data, rob_set_pc_en, rob_set_pc, icache_flush
  );
endinterface

// File: rtl/ifetch_icache.sv
// Instruction fetch unit with a 1/2-way set-associative instruction cache,
// block refill from the memory controller, redirect and whole-cache invalidate.
module ifetch_icache #(
  parameter int          BLK_WORDS = 16,
  parameter int          SETS      = 16,
  parameter int          WAYS      = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rs_nxt_full,
  input  logic lsb_nxt_full,
  input  logic rob_nxt_full,
  ifetch_icache_if.master bus
);
  localparam int OFF_W = $clog2(BLK_WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int WRD_W = OFF_W - 2;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  logic [31:0]                 pc_reg;
  logic [0:0]                  state_reg;
  logic                        drop_reg;
  logic [WAYS-1:0][SETS-1:0]   valid_reg;
  logic [SETS-1:0]             lru_reg;
  logic                        inst_rdy_reg;
  logic [31:0]                 inst_reg;
  logic [31:0]                 inst_pc_reg;
  logic                        mc_en_reg;
  logic [31:0]                 mc_pc_reg;

  logic [WRD_W-1:0]            word;
  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            tag;
  logic [IDX_W-1:0]            fill_idx;
  logic [TAG_W-1:0]            fill_tag;
  logic [WAYS-1:0]             hit_way;
  logic [WAYS-1:0][31:0]       word_way;
  logic                        hit;
  logic                        hit_sel;
  logic                        victim;
  logic                        fill_we;
  logic                        stall;
  logic                        issue;
  logic                        unused_bits;

  assign word     = pc_reg[OFF_W-1:2];
  assign idx      = pc_reg[OFF_W+IDX_W-1:OFF_W];
  assign tag      = pc_reg[31:OFF_W+IDX_W];
  assign fill_idx = mc_pc_reg[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = mc_pc_reg[31:OFF_W+IDX_W];
  assign unused_bits = ^{pc_reg[1:0], mc_pc_reg[OFF_W-1:0]};

  // A fill coinciding with a flush (or after one during the wait) is discarded.
  assign fill_we = (state_reg == WAIT_MEM) && bus.mc_done && !drop_reg && !bus.icache_flush;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : way_g
      logic [TAG_W-1:0]         tag_mem  [SETS];
      logic [32*BLK_WORDS-1:0]  data_mem [SETS];

      always_ff @(posedge clk) begin
        if (rdy && fill_we && (victim == 1'(gi))) begin
          tag_mem[fill_idx]  <= fill_tag;
          data_mem[fill_idx] <= bus.mc_data;
        end
      end

      assign hit_way[gi]  = valid_reg[gi][idx] && (tag_mem[idx] == tag);
      assign word_way[gi] = data_mem[idx][32*word +: 32];
    end
  endgenerate

  assign hit     = |hit_way;
  assign hit_sel = (WAYS == 2) ? hit_way[WAYS-1] : 1'b0;
  assign stall   = rs_nxt_full | lsb_nxt_full | rob_nxt_full;
  assign issue   = !bus.rob_set_pc_en && !bus.icache_flush && hit && !stall;

  // Victim: first invalid way (way0 first), otherwise the least recently used way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid_reg[0][fill_idx])
        victim = 1'b0;
      else if (!valid_reg[WAYS-1][fill_idx])
        victim = 1'b1;
      else
        victim = lru_reg[fill_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      state_reg    <= IDLE;
      drop_reg     <= 1'b0;
      valid_reg    <= '0;
      lru_reg      <= '0;
      inst_rdy_reg <= 1'b0;
      inst_reg     <= 32'h0;
      inst_pc_reg  <= 32'h0;
      mc_en_reg    <= 1'b0;
      mc_pc_reg    <= 32'h0;
    end else if (rdy) begin
      if (bus.rob_set_pc_en) begin
        pc_reg       <= bus.rob_set_pc;
        inst_rdy_reg <= 1'b0;
      end else if (issue) begin
        inst_reg     <= word_way[hit_sel];
        inst_pc_reg  <= pc_reg;
        inst_rdy_reg <= 1'b1;
        pc_reg       <= pc_reg + 32'd4;
      end else begin
        inst_rdy_reg <= 1'b0;
      end

      if (issue && (WAYS == 2))
        lru_reg[idx] <= ~hit_sel;

      if (bus.icache_flush)
        valid_reg <= '0;

      case (state_reg)
        IDLE: begin
          if (!hit && !bus.rob_set_pc_en && !bus.icache_flush) begin
            mc_en_reg <= 1'b1;
            mc_pc_reg <= {pc_reg[31:OFF_W], {OFF_W{1'b0}}};
            drop_reg  <= 1'b0;
            state_reg <= WAIT_MEM;
          end
        end
        default: begin
          if (bus.icache_flush)
            drop_reg <= 1'b1;
          if (bus.mc_done) begin
            mc_en_reg <= 1'b0;
            state_reg <= IDLE;
            // Written after the issue-side LRU update so a fill into the same set wins.
            if (fill_we) begin
              valid_reg[victim][fill_idx] <= 1'b1;
              if (WAYS == 2)
                lru_reg[fill_idx] <= ~victim;
            end
          end
        end
      endcase
    end
  end

  assign bus.inst_rdy = inst_rdy_reg;
  assign bus.inst     = inst_reg;
  assign bus.inst_pc  = inst_pc_reg;
  assign bus.mc_en    = mc_en_reg;
  assign bus.mc_pc    = mc_pc_reg;
endmodule

// File: tb/tb_ifetch_icache.sv
// Directed bench for ifetch_icache: refill, stall, LRU eviction, redirect during
// refill, flush during refill, rdy freeze and asynchronous reset.
module tb_ifetch_icache;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic rs_nxt_full = 1'b0;
  logic lsb_nxt_full = 1'b0;
  logic rob_nxt_full = 1'b0;
  int   total = 0;
  int   bad = 0;

  ifetch_icache_if #(.BLK_WORDS(BW)) bus ();

  ifetch_icache #(
    .BLK_WORDS(BW), .SETS(16), .WAYS(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs_nxt_full(rs_nxt_full), .lsb_nxt_full(lsb_nxt_full), .rob_nxt_full(rob_nxt_full),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [32*BW-1:0] blk(input logic [31:0] base);
    logic [32*BW-1:0] d;
    d = '0;
    for (int i = 0; i < BW; i++) d[32*i +: 32] = base + 32'(i);
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    bus.rob_set_pc_en = 1'b1;
    bus.rob_set_pc    = a;
    tick();
    bus.rob_set_pc_en = 1'b0;
  endtask

  task automatic refill(input logic [31:0] base);
    bus.mc_done = 1'b1;
    bus.mc_data = blk(base);
    tick();
    bus.mc_done = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] a);
    tick();
    check({tag, ".mc_en"}, 32'(bus.mc_en), 32'd1);
    check({tag, ".mc_pc"}, bus.mc_pc, a);
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    tick();
    check({tag, ".rdy"}, 32'(bus.inst_rdy), 32'd1);
    check({tag, ".inst"}, bus.inst, ins);
    check({tag, ".pc"}, bus.inst_pc, pc);
    check({tag, ".mc_en"}, 32'(bus.mc_en), 32'd0);
  endtask

  initial begin
    bus.mc_done = 1'b0;
    bus.mc_data = '0;
    bus.rob_set_pc_en = 1'b0;
    bus.rob_set_pc = 32'h0;
    bus.icache_flush = 1'b0;

    // 1: reset, first refill, streaming
    tick(); tick();
    check("rst.inst_rdy", 32'(bus.inst_rdy), 32'd0);
    check("rst.mc_en", 32'(bus.mc_en), 32'd0);
    check("rst.mc_pc", bus.mc_pc, 32'h0);
    check("rst.inst", bus.inst, 32'h0);
    rst = 1'b0;
    expect_req("t1.req", 32'h0);
    refill(32'h1000);
    check("t1.done.mc_en", 32'(bus.mc_en), 32'd0);
    check("t1.done.rdy", 32'(bus.inst_rdy), 32'd0);
    expect_issue("t1.i0", 32'h0, 32'h1000);
    expect_issue("t1.i1", 32'h4, 32'h1001);
    expect_issue("t1.i2", 32'h8, 32'h1002);

    // 2: stall for three cycles, resume at the next word
    rob_nxt_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2.stall.rdy", 32'(bus.inst_rdy), 32'd0);
    end
    rob_nxt_full = 1'b0;
    expect_issue("t2.i3", 32'hC, 32'h1003);
    expect_issue("t2.i4", 32'h10, 32'h1004);

    // 3: two lines in set 0, touch 0x000, then 0x800 evicts 0x400
    redirect(32'h400);
    check("t3.redir.rdy", 32'(bus.inst_rdy), 32'd0);
    check("t3.redir.mc_en", 32'(bus.mc_en), 32'd0);
    expect_req("t3.req400", 32'h400);
    refill(32'h4000);
    expect_issue("t3.a0", 32'h400, 32'h4000);
    expect_issue("t3.a1", 32'h404, 32'h4001);
    redirect(32'h0);
    expect_issue("t3.b0", 32'h0, 32'h1000);
    redirect(32'h800);
    expect_req("t3.req800", 32'h800);
    refill(32'h8000);
    expect_issue("t3.c0", 32'h800, 32'h8000);
    redirect(32'h4);
    expect_issue("t3.keep0", 32'h4, 32'h1001);
    redirect(32'h400);
    expect_req("t3.evicted400", 32'h400);
    refill(32'h4000);
    expect_issue("t3.a0b", 32'h400, 32'h4000);

    // 4: redirect while a refill of 0x40 is outstanding
    redirect(32'h40);
    expect_req("t4.req40", 32'h40);
    redirect(32'h2000);
    check("t4.hold.mc_en", 32'(bus.mc_en), 32'd1);
    check("t4.hold.mc_pc", bus.mc_pc, 32'h40);
    refill(32'h5000);
    check("t4.done.mc_en", 32'(bus.mc_en), 32'd0);
    expect_req("t4.req2000", 32'h2000);
    refill(32'h6000);
    expect_issue("t4.first", 32'h2000, 32'h6000);
    redirect(32'h44);
    expect_issue("t4.line40", 32'h44, 32'h5001);

    // 5: flush during WAIT_MEM, mc_done one cycle later -> fill dropped
    redirect(32'h80);
    expect_req("t5.req80", 32'h80);
    bus.icache_flush = 1'b1;
    tick();
    bus.icache_flush = 1'b0;
    check("t5.flush.mc_en", 32'(bus.mc_en), 32'd1);
    refill(32'h7000);
    check("t5.done.mc_en", 32'(bus.mc_en), 32'd0);
    expect_req("t5.rereq80", 32'h80);
    check("t5.rereq.rdy", 32'(bus.inst_rdy), 32'd0);
    refill(32'h7000);
    expect_issue("t5.i0", 32'h80, 32'h7000);
    redirect(32'h44);
    expect_req("t5.inval40", 32'h40);
    refill(32'h5000);
    expect_issue("t5.line40", 32'h44, 32'h5001);

    // 6: rdy=0 over mc_done, then asynchronous reset mid-refill
    redirect(32'h100);
    expect_req("t6.req100", 32'h100);
    rdy = 1'b0;
    refill(32'h9000);
    rdy = 1'b1;
    check("t6.frozen.mc_en", 32'(bus.mc_en), 32'd1);
    tick();
    check("t6.wait.mc_en", 32'(bus.mc_en), 32'd1);
    check("t6.wait.rdy", 32'(bus.inst_rdy), 32'd0);
    rst = 1'b1;
    #1;
    check("t6.arst.mc_en", 32'(bus.mc_en), 32'd0);
    check("t6.arst.mc_pc", bus.mc_pc, 32'h0);
    check("t6.arst.inst", bus.inst, 32'h0);
    check("t6.arst.inst_pc", bus.inst_pc, 32'h0);
    tick();
    rst = 1'b0;
    bus.mc_done = 1'b1;
    bus.mc_data = blk(32'hA000);
    tick();
    bus.mc_done = 1'b0;
    check("t6.post.mc_en", 32'(bus.mc_en), 32'd1);
    check("t6.post.mc_pc", bus.mc_pc, 32'h0);
    tick();
    check("t6.still.mc_en", 32'(bus.mc_en), 32'd1);
    refill(32'h1000);
    expect_issue("t6.i0", 32'h0, 32'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
